// File: rtl/toggle_cov_pkg.sv
// Shared constants and helpers for toggle coverage: point numbering and count sizing.
package toggle_cov_pkg;

   localparam int unsigned RISE_OFS = 0;
   localparam int unsigned FALL_OFS = 1;

   // Coverage point index of an edge on a monitored bit.
   function automatic int unsigned point_idx(input int unsigned bit_i, input int unsigned ofs);
      return 2 * bit_i + ofs;
   endfunction

   // Bits needed to hold a count of 0..2*w distinct points.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(2 * w + 1);
   endfunction

endpackage

// File: rtl/toggle_popcount.sv
// Combinational population count of an N-bit vector.
module toggle_popcount #(
   parameter int unsigned N  = 62,
   parameter int unsigned CW = $clog2(N + 1)
) (
   input  logic [N-1:0]  bits_i,
   output logic [CW-1:0] count_o_c
);

   logic [N-1:0] shift_c;

   // Shift-and-accumulate keeps every select constant.
   always_comb begin
      count_o_c = '0;
      shift_c   = bits_i;
      for (int unsigned i = 0; i < N; i++) begin
         count_o_c = count_o_c + CW'(shift_c[0]);
         shift_c   = shift_c >> 1;
      end
   end

endmodule

// File: rtl/toggle_event_detector.sv
// Per-bit rise/fall detector with sticky hit mask, registered event pulses
// and a running count of distinct coverage points hit.
module toggle_event_detector
   import toggle_cov_pkg::*;
#(
   parameter int unsigned WIDTH     = 31,
   parameter bit          ONCE_ONLY = 1'b1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [WIDTH-1:0]              sig,
   input  logic                          clear,
   output logic [2*WIDTH-1:0]            valid,
   output logic [cnt_width(WIDTH)-1:0]   covered_count,
   output logic                          all_covered
);

   localparam int unsigned NPTS = 2 * WIDTH;
   localparam int unsigned CW   = cnt_width(WIDTH);

   logic [WIDTH-1:0] prev_q;
   logic             hist_q;
   logic [NPTS-1:0]  mask_q,  mask_d;
   logic [NPTS-1:0]  valid_q, valid_d;
   logic [CW-1:0]    count_q, count_d;
   logic             all_q,   all_d;

   logic [NPTS-1:0]  det_c;
   logic [NPTS-1:0]  base_mask_c;
   logic [NPTS-1:0]  new_hits_c;
   logic [CW-1:0]    base_count_c;
   logic [CW-1:0]    new_cnt_c;

   // Interleave rise/fall detections into the point vector.
   for (genvar g = 0; g < WIDTH; g++) begin : g_det
      assign det_c[point_idx(g, RISE_OFS)] = hist_q & ~prev_q[g] &  sig[g];
      assign det_c[point_idx(g, FALL_OFS)] = hist_q &  prev_q[g] & ~sig[g];
   end

   toggle_popcount #(
      .N  (NPTS),
      .CW (CW)
   ) u_popcount (
      .bits_i    (new_hits_c),
      .count_o_c (new_cnt_c)
   );

   // Clear empties the mask before this cycle's detections are judged.
   always_comb begin
      base_mask_c  = clear ? '0 : mask_q;
      base_count_c = clear ? '0 : count_q;
      new_hits_c   = det_c & ~base_mask_c;
      mask_d       = base_mask_c | det_c;
      count_d      = base_count_c + new_cnt_c;
      all_d        = (count_d == CW'(NPTS));
      valid_d      = ONCE_ONLY ? new_hits_c : det_c;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_q  <= '0;
         hist_q  <= 1'b0;
         mask_q  <= '0;
         valid_q <= '0;
         count_q <= '0;
         all_q   <= 1'b0;
      end else begin
         prev_q  <= sig;
         hist_q  <= 1'b1;
         mask_q  <= mask_d;
         valid_q <= valid_d;
         count_q <= count_d;
         all_q   <= all_d;
      end
   end

   assign valid         = valid_q;
   assign covered_count = count_q;
   assign all_covered   = all_q;

endmodule

// File: tb/tb_toggle_event_detector.sv
// Scoreboard bench: two detectors (report-once and report-every) driven in
// lockstep and checked against a set-based model of the coverage rules.
module tb_toggle_event_detector;

   localparam int W  = 31;
   localparam int NP = 2 * W;

   typedef struct packed {
      logic [NP-1:0] v_once;
      logic [NP-1:0] v_every;
      logic [5:0]    cnt;
      logic          all_c;
   } exp_t;

   logic          clock;
   logic          reset;
   logic [W-1:0]  sig;
   logic          clear;
   logic [NP-1:0] valid_a, valid_b;
   logic [5:0]    count_a, count_b;
   logic          all_a, all_b;

   toggle_event_detector #(.WIDTH(W), .ONCE_ONLY(1'b1)) dut_once (
      .clock(clock), .reset(reset), .sig(sig), .clear(clear),
      .valid(valid_a), .covered_count(count_a), .all_covered(all_a));

   toggle_event_detector #(.WIDTH(W), .ONCE_ONLY(1'b0)) dut_every (
      .clock(clock), .reset(reset), .sig(sig), .clear(clear),
      .valid(valid_b), .covered_count(count_b), .all_covered(all_b));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state: set of points hit, last sampled value, history flag.
   bit          hit[NP];
   logic [W-1:0] m_prev;
   bit          m_hist;

   task automatic check(input string name, input logic [NP-1:0] got, input logic [NP-1:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   // Monitor: outputs are registered, so every cycle presents one result.
   always @(posedge clock) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("valid_once",  valid_a, e.v_once);
         check("valid_every", valid_b, e.v_every);
         check("count_once",  NP'(count_a), NP'(e.cnt));
         check("count_every", NP'(count_b), NP'(e.cnt));
         check("all_covered", NP'(all_a), NP'(e.all_c));
      end
   end

   task automatic drive(input logic [W-1:0] s, input logic c, input logic r);
      exp_t e;
      int   p;
      int   n;
      e = '0;
      if (r) begin
         foreach (hit[k]) hit[k] = 1'b0;
         m_hist = 1'b0;
      end else begin
         if (c) foreach (hit[k]) hit[k] = 1'b0;
         if (m_hist) begin
            for (int i = 0; i < W; i++) begin
               if (m_prev[i] != s[i]) begin
                  p = s[i] ? 2 * i : 2 * i + 1;
                  e.v_every = e.v_every | (NP'(1) << p);
                  if (!hit[p]) begin
                     e.v_once = e.v_once | (NP'(1) << p);
                     hit[p] = 1'b1;
                  end
               end
            end
         end
         m_prev = s;
         m_hist = 1'b1;
         n = 0;
         foreach (hit[k]) n += int'(hit[k]);
         e.cnt   = 6'(n);
         e.all_c = (n == NP);
      end
      sig   = s;
      clear = c;
      reset = r;
      exp_q.push_back(e);
      @(posedge clock);
      #2;
   endtask

   initial begin
      logic [W-1:0] pat;
      m_prev = '0;
      m_hist = 1'b0;
      foreach (hit[k]) hit[k] = 1'b0;
      sig = '0; clear = 1'b0; reset = 1'b1;
      #2;

      drive('0, 1'b0, 1'b1);
      drive('0, 1'b0, 1'b1);
      // All-ones held from reset release: never any event.
      for (int i = 0; i < 6; i++) drive('1, 1'b0, 1'b0);

      drive('0, 1'b0, 1'b1);
      drive('0, 1'b0, 1'b0);
      drive('0, 1'b0, 1'b0);
      drive(W'(1), 1'b0, 1'b0);
      drive(W'(1), 1'b0, 1'b0);
      drive('0, 1'b0, 1'b0);
      drive(W'(1), 1'b0, 1'b0);

      // Full rise then full fall reaches complete coverage.
      drive('0, 1'b1, 1'b0);
      drive('1, 1'b0, 1'b0);
      drive('0, 1'b0, 1'b0);
      drive('0, 1'b0, 1'b0);

      // Clear coinciding with a fall on bit 5.
      drive(W'(32'h20), 1'b0, 1'b0);
      drive('0, 1'b1, 1'b0);
      drive('0, 1'b0, 1'b0);

      // Bit 3 toggling every cycle.
      for (int i = 0; i < 10; i++) drive((i % 2 == 0) ? W'(8) : W'(0), 1'b0, 1'b0);

      // Reset landing on a cycle with detections pending.
      drive('0, 1'b0, 1'b0);
      pat = W'(32'h5A5A_1234);
      drive(pat, 1'b0, 1'b1);
      drive(pat, 1'b0, 1'b0);
      drive(pat, 1'b0, 1'b0);
      drive(~pat, 1'b0, 1'b0);

      for (int i = 0; i < 400; i++) begin
         drive(W'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 63) == 0));
      end
      drive('0, 1'b0, 1'b0);

      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d results left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/toggle_event_detector.md
TOGGLE_EVENT_DETECTOR -- requirements
Module: toggle_event_detector

Interface
REQ-001 SHALL have parameter WIDTH, default 31, meaning the number of monitored signal bits.
REQ-002 SHALL have parameter ONCE_ONLY, default 1, meaning each coverage point is reported at most once until rearmed; 0 means every occurrence is reported.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port sig, input, WIDTH bits: the monitored signals, sampled every cycle.
REQ-006 SHALL have port clear, input, 1 bit: rearms all coverage points (clears the hit mask and the count).
REQ-007 SHALL have port valid, output, 2*WIDTH bits: one-cycle event pulses; this port connects directly to the toggle coverage reporter's valid input.
REQ-008 SHALL have port covered_count, output, $clog2(2*WIDTH+1) bits: the number of distinct points hit since the last reset or clear.
REQ-009 SHALL have port all_covered, output, 1 bit: high while covered_count equals 2*WIDTH.

Function
REQ-010 SHALL register sig each cycle into prev, and SHALL set a hist_valid flag one cycle after reset deasserts.
REQ-011 SHALL detect a rise on bit i when hist_valid & ~prev[i] & sig[i], and a fall on bit i when hist_valid & prev[i] & ~sig[i].
REQ-012 SHALL map bit i to point index 2i for a rise and 2i+1 for a fall.
REQ-013 SHALL register valid, so a pulse appears exactly one cycle after the cycle in which sig differs from prev.
REQ-014 SHALL hold each valid bit high for one cycle per detection and SHALL NOT stretch it.
REQ-015 SHALL keep a sticky hit mask of 2*WIDTH bits; with ONCE_ONLY=1, SHALL mask a detection whose mask bit is already set.
REQ-016 SHALL, with ONCE_ONLY=0, pass every detection to valid, while the mask and count still track distinct points.
REQ-017 SHALL add the popcount of newly set mask bits to covered_count in the same registered update that asserts valid.
REQ-018 SHALL never let covered_count exceed 2*WIDTH, which is structurally guaranteed by the mask.
REQ-019 SHALL, when clear=1, zero the mask and count first; detections in that same cycle are then evaluated against the empty mask, reported, and counted.
REQ-020 SHALL NOT let clear affect prev or hist_valid, so edges are still detected across a clear.
REQ-021 SHALL produce no detections in the first sampled cycle after reset, because hist_valid=0.
REQ-022 SHALL register all_covered alongside covered_count, with no extra latency.

Reset
REQ-023 SHALL, on reset=1 at a clock edge, set to zero on the next cycle: valid, covered_count, all_covered, the mask, prev, and hist_valid.
REQ-024 SHALL give reset asserted mid-operation priority over clear and over any detection, and SHALL drop pending pulses.

Structure
REQ-025 SHALL place the following in shared package toggle_cov_pkg: the RISE_OFS=0 / FALL_OFS=1 constants, the point-index function (2*i+ofs), and the count-width function ($clog2(2*W+1)).
REQ-026 SHALL instantiate exactly one sub-module, toggle_popcount, a parameterised combinational popcount of the newly-hit vector.
REQ-027 SHALL contain no DPI calls, and SHALL be synthesizable.

Verification
REQ-028 SHALL cover: reset released with sig=all-ones held → valid stays 0 and covered_count=0 indefinitely.
REQ-029 SHALL cover: sig[0] 0→1 at cycle N → valid[0]=1 at N+1 only, covered_count=1; repeating the rise with ONCE_ONLY=1 → no pulse, count stays 1.
REQ-030 SHALL cover: all 31 bits rise then fall on consecutive cycles → valid=even bits, then odd bits; covered_count=31, then 62; all_covered=1.
REQ-031 SHALL cover: clear=1 in the same cycle sig[5] falls → valid[11]=1 next cycle, covered_count=1.
REQ-032 SHALL cover: ONCE_ONLY=0 with sig[3] toggling every cycle for 10 cycles → valid[6]/valid[7] alternate for 10 pulses, covered_count=2.
REQ-033 SHALL cover: reset asserted during a cycle with detections pending → valid=0 next cycle, covered_count=0, and no pulse on the first cycle after release.
